// File: rtl/fp_operand_stage_if.sv
// Handshake and result bundle between the FP adder operand stage and its neighbours.
// master drives operands and FlagResult; slave is the operand stage itself.
interface fp_operand_stage_if #(
  parameter int EXPBITS      = 8,
  parameter int MANTISSABITS = 23
);
  localparam int W = 1 + EXPBITS + MANTISSABITS;

  logic                    InValid;
  logic                    InReady;
  logic [W-1:0]            OpA;
  logic [W-1:0]            OpB;
  logic                    Go;
  logic                    FlagResult;
  logic                    SignA;
  logic                    SignB;
  logic [EXPBITS-1:0]      ExpA;
  logic [EXPBITS-1:0]      ExpB;
  logic [MANTISSABITS:0]   MantA;
  logic [MANTISSABITS:0]   MantB;
  logic                    ExpSet;
  logic [EXPBITS-1:0]      ExpDiff;
  logic [EXPBITS-1:0]      Diff;
  logic                    SpecialValid;
  logic [W-1:0]            SpecialResult;
  logic                    Error;

  modport master (
    output InValid, OpA, OpB, FlagResult,
    input  InReady, Go, SignA, SignB, ExpA, ExpB, MantA, MantB,
           ExpSet, ExpDiff, Diff, SpecialValid, SpecialResult, Error
  );

  modport slave (
    input  InValid, OpA, OpB, FlagResult,
    output InReady, Go, SignA, SignB, ExpA, ExpB, MantA, MantB,
           ExpSet, ExpDiff, Diff, SpecialValid, SpecialResult, Error
  );
endinterface

// File: rtl/fp_operand_stage.sv
// FP adder operand stage: unpacks a handshaked operand pair, computes the exponent
// compare for the adder control FSM, and short-circuits NaN/Inf/zero operands.
//
// state   | meaning
// IDLE    | ready for a new operand pair
// DECODE  | register unpacked fields and classify
// ISSUE   | Go pulse to the control FSM
// WAIT    | wait for FlagResult under watchdog
// SPECIAL | SpecialValid pulse, bypass result
module fp_operand_stage #(
  parameter int EXPBITS      = 8,
  parameter int MANTISSABITS = 23,
  parameter int TIMEOUT      = 64
) (
  input logic               Clock,
  input logic               Reset,
  fp_operand_stage_if.slave bus
);
  localparam int W  = 1 + EXPBITS + MANTISSABITS;
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] QNAN = {1'b0, {EXPBITS{1'b1}}, 1'b1, {(MANTISSABITS-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, DECODE, ISSUE, WAIT, SPECIAL} state_t;

  state_t                 state_q, state_d;
  logic [W-1:0]           op_a_q, op_a_d, op_b_q, op_b_d;
  logic                   sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [EXPBITS-1:0]     exp_a_q, exp_a_d, exp_b_q, exp_b_d;
  logic [MANTISSABITS:0]  mant_a_q, mant_a_d, mant_b_q, mant_b_d;
  logic                   exp_set_q, exp_set_d;
  logic [EXPBITS-1:0]     exp_diff_q, exp_diff_d, diff_q, diff_d;
  logic [W-1:0]           special_result_q, special_result_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   error_q, error_d;

  logic [EXPBITS-1:0]      fld_a, fld_b, eff_a, eff_b, abs_diff, sat_diff;
  logic [MANTISSABITS-1:0] frac_a, frac_b;
  logic [MANTISSABITS:0]   man_a, man_b;
  logic                    nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  logic                    a_ge_b, is_special;
  logic [W-1:0]            special_val;

  always_comb begin
    fld_a    = op_a_q[W-2 -: EXPBITS];
    fld_b    = op_b_q[W-2 -: EXPBITS];
    frac_a   = op_a_q[MANTISSABITS-1:0];
    frac_b   = op_b_q[MANTISSABITS-1:0];
    // Denormals share the minimum normal exponent but carry no hidden bit.
    eff_a    = (fld_a == '0) ? EXPBITS'(1) : fld_a;
    eff_b    = (fld_b == '0) ? EXPBITS'(1) : fld_b;
    man_a    = {(fld_a != '0), frac_a};
    man_b    = {(fld_b != '0), frac_b};
    nan_a    = (&fld_a) && (frac_a != '0);
    nan_b    = (&fld_b) && (frac_b != '0);
    inf_a    = (&fld_a) && (frac_a == '0);
    inf_b    = (&fld_b) && (frac_b == '0);
    zero_a   = (fld_a == '0) && (frac_a == '0);
    zero_b   = (fld_b == '0) && (frac_b == '0);
    a_ge_b   = (eff_a > eff_b) || ((eff_a == eff_b) && (man_a >= man_b));
    abs_diff = (eff_a >= eff_b) ? (eff_a - eff_b) : (eff_b - eff_a);
    sat_diff = (abs_diff > EXPBITS'(MANTISSABITS)) ? EXPBITS'(MANTISSABITS) : abs_diff;

    is_special  = 1'b1;
    special_val = '0;
    if (nan_a || nan_b)
      special_val = QNAN;
    else if (inf_a && inf_b && (op_a_q[W-1] != op_b_q[W-1]))
      special_val = QNAN;
    else if (inf_a)
      special_val = op_a_q;
    else if (inf_b)
      special_val = op_b_q;
    else if (zero_a && zero_b)
      special_val = {op_a_q[W-1] & op_b_q[W-1], {(W-1){1'b0}}};
    else if (zero_a)
      special_val = op_b_q;
    else if (zero_b)
      special_val = op_a_q;
    else
      is_special = 1'b0;
  end

  always_comb begin
    state_d          = state_q;
    op_a_d           = op_a_q;
    op_b_d           = op_b_q;
    sign_a_d         = sign_a_q;
    sign_b_d         = sign_b_q;
    exp_a_d          = exp_a_q;
    exp_b_d          = exp_b_q;
    mant_a_d         = mant_a_q;
    mant_b_d         = mant_b_q;
    exp_set_d        = exp_set_q;
    exp_diff_d       = exp_diff_q;
    diff_d           = diff_q;
    special_result_d = special_result_q;
    cnt_d            = cnt_q;
    error_d          = error_q;

    case (state_q)
      IDLE: begin
        if (bus.InValid) begin
          op_a_d  = bus.OpA;
          op_b_d  = bus.OpB;
          state_d = DECODE;
        end
      end
      DECODE: begin
        sign_a_d   = op_a_q[W-1];
        sign_b_d   = op_b_q[W-1];
        exp_a_d    = eff_a;
        exp_b_d    = eff_b;
        mant_a_d   = man_a;
        mant_b_d   = man_b;
        exp_set_d  = a_ge_b;
        exp_diff_d = abs_diff;
        diff_d     = sat_diff;
        if (is_special) begin
          special_result_d = special_val;
          state_d          = SPECIAL;
        end else begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // FlagResult takes priority over a coincident watchdog expiry.
        if (bus.FlagResult) begin
          state_d = IDLE;
        end else if (cnt_q == CW'(TIMEOUT-1)) begin
          error_d = 1'b1;
          state_d = IDLE;
        end
      end
      SPECIAL: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q          <= IDLE;
      op_a_q           <= '0;
      op_b_q           <= '0;
      sign_a_q         <= 1'b0;
      sign_b_q         <= 1'b0;
      exp_a_q          <= '0;
      exp_b_q          <= '0;
      mant_a_q         <= '0;
      mant_b_q         <= '0;
      exp_set_q        <= 1'b0;
      exp_diff_q       <= '0;
      diff_q           <= '0;
      special_result_q <= '0;
      cnt_q            <= '0;
      error_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      op_a_q           <= op_a_d;
      op_b_q           <= op_b_d;
      sign_a_q         <= sign_a_d;
      sign_b_q         <= sign_b_d;
      exp_a_q          <= exp_a_d;
      exp_b_q          <= exp_b_d;
      mant_a_q         <= mant_a_d;
      mant_b_q         <= mant_b_d;
      exp_set_q        <= exp_set_d;
      exp_diff_q       <= exp_diff_d;
      diff_q           <= diff_d;
      special_result_q <= special_result_d;
      cnt_q            <= cnt_d;
      error_q          <= error_d;
    end
  end

  assign bus.InReady       = (state_q == IDLE);
  assign bus.Go            = (state_q == ISSUE);
  assign bus.SpecialValid  = (state_q == SPECIAL);
  assign bus.SignA         = sign_a_q;
  assign bus.SignB         = sign_b_q;
  assign bus.ExpA          = exp_a_q;
  assign bus.ExpB          = exp_b_q;
  assign bus.MantA         = mant_a_q;
  assign bus.MantB         = mant_b_q;
  assign bus.ExpSet        = exp_set_q;
  assign bus.ExpDiff       = exp_diff_q;
  assign bus.Diff          = diff_q;
  assign bus.SpecialResult = special_result_q;
  assign bus.Error         = error_q;
endmodule
